rr_chan_mux: RTL and testbench
==============================

// Module: rr_chan_mux
// PURPOSE
//  Parametrised N-channel, W-bit arbitrated multiplexer; generalises the fixed 5:1/20:1 mux trees.
//  An FSM picks one requesting channel, by round-robin or fixed priority, and registers its data.
//  It presents the data downstream under a valid/ready handshake and pulses a one-hot ack back.
//  Sits between per-channel producers and a single shared consumer.
// PARAMETERS
//  NCH   20  number of input channels (>=2)
//  W     8   data width per channel
//  MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  CW    $clog2(NCH)  derived; channel-index width (localparam)
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  reset      in   1      asynchronous, active-low reset
//  enable     in   1      1 = new grants allowed; 0 = no new grant (pending transfer unaffected)
//  req        in   NCH    per-channel request, level
//  data       in   NCH*W  channel i on data[W*i+W-1 : W*i]
//  ack        out  NCH    one-hot, 1-cycle pulse: granted channel captured
//  out_valid  out  1      out_data/out_chan hold a pending transfer
//  out_ready  in   1      consumer accepts when out_valid & out_ready at posedge
//  out_data   out  W      captured channel data
//  out_chan   out  CW     index of captured channel
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; out_valid=0, out_data=0, out_chan=0, ack=0; ptr=0.
//  Any pending transfer is discarded and no ack is reissued after release.
//  States: IDLE, HOLD (2 states; 1-bit encoding).
//  IDLE -> HOLD when enable & |req at posedge:
//   - MODE 0: winner = first set req bit scanning ptr, ptr+1, .. NCH-1, 0, .. ptr-1.
//   - MODE 1: winner = lowest set req bit; ptr ignored.
//   - Same edge: out_data <= data[winner], out_chan <= winner, out_valid <= 1, ack <= onehot(winner).
//   - ptr <= (winner==NCH-1) ? 0 : winner+1, updated in MODE 0 only.
//  IDLE stays IDLE if !enable or req==0. ack=0. out_ready is ignored in IDLE.
//  HOLD: out_valid=1. out_data/out_chan are stable even if data/req change. ack=0 (pulse lasts 1 cycle).
//  HOLD -> IDLE when out_ready=1 at posedge; out_valid <= 0. out_data/out_chan retain their last values.
//  HOLD stays HOLD while out_ready=0, for unbounded backpressure; enable has no effect.
//  Latency: req seen at edge k -> out_valid and ack high after edge k. Peak rate is 1 transfer / 2 cycles.
//  Producer must drop req by the edge after its ack. A still-high req is re-eligible in the next IDLE.
//  Fairness in MODE 0: any channel holding req is served within NCH grants.
//  ptr wrap: a grant to NCH-1 sets ptr=0; a ptr value >= NCH is unreachable.
//  enable falling while in HOLD: current transfer completes, then the FSM parks in IDLE.
// STRUCTURE
//  Package rr_chan_mux_pkg: ST_IDLE=1'b0, ST_HOLD=1'b1; MODE_RR=0, MODE_FIXED=1.
//  Sub-module rr_select (combinational): inputs req, base, mode; outputs found and idx [CW-1:0].
//  rr_select does a rotating-base priority search; the top level keeps the FSM, ptr and output registers.
//  Data select uses an indexed part-select on data by winner; no hand-built mux tree.
// TESTING  (NCH=20, W=8 unless noted)
//  1 reset=0, req=20'hFFFFF, toggle clk 5 cycles -> out_valid=0, ack=0, out_chan=0.
//    Release reset -> first grant is chan 0, ack=20'h00001.
//  2 MODE 0, req=20'hFFFFF, out_ready=1, data[i]=i+8'h10 -> out_chan 0,1,..,19,0, one grant every 2 cycles.
//    out_data matches each channel; wrap 19->0 occurs.
//  3 MODE 0, ptr=5 (after a grant to 4), req bits 3 and 17 -> grant 17 then 3. ack=20'h20000 then 20'h00008.
//  4 Grant chan 7 (data=8'hA5), hold out_ready=0 for 6 cycles while changing data[7] to 8'h00.
//    -> out_valid=1 and out_data=8'hA5 throughout; no further ack. Accept -> out_valid=0 next cycle.
//  5 MODE 1, req bits 3 and 17 held high, out_ready=1 -> every grant is chan 3.
//    enable=0 -> no grant after the current HOLD completes.
//  6 Assert reset mid-HOLD (out_chan=12) -> out_valid drops immediately without waiting for a clock edge.
//    After release with req=20'hFFFFF -> grant chan 0 (ptr cleared).

Source files
------------

// File: rtl/rr_chan_mux_pkg.sv
// rtl/rr_chan_mux_pkg.sv - shared types and constants for the arbitrated channel mux
package rr_chan_mux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - rotating-base priority search over a request vector
module rr_select #(
   parameter int NCH = 20,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  base,
   input  logic           mode,
   output logic           found,
   output logic [CW-1:0]  idx
);

   // Scan from the highest offset down so the lowest offset from base wins last.
   always_comb begin
      int start;
      int pos;
      found = 1'b0;
      idx   = '0;
      start = mode ? 0 : int'(base);
      pos   = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         pos = start + i;
         if (pos >= NCH) pos = pos - NCH;
         if (req[pos]) begin
            found = 1'b1;
            idx   = CW'(pos);
         end
      end
   end

endmodule

// File: rtl/rr_chan_mux.sv
// rtl/rr_chan_mux.sv - N-channel arbitrated mux with registered valid/ready output and ack pulse
module rr_chan_mux
   import rr_chan_mux_pkg::*;
#(
   parameter  int NCH  = 20,
   parameter  int W    = 8,
   parameter  int MODE = MODE_RR,
   localparam int CW   = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NCH-1:0]   req,
   input  logic [NCH*W-1:0] data,
   output logic [NCH-1:0]   ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [CW-1:0]    out_chan
);

   state_t          state;
   logic [CW-1:0]   ptr;
   logic            found;
   logic [CW-1:0]   winner;
   logic [W-1:0]    win_data;
   logic [NCH-1:0]  win_onehot;

   rr_select #(
      .NCH (NCH),
      .CW  (CW)
   ) u_select (
      .req   (req),
      .base  (ptr),
      .mode  (MODE == MODE_FIXED),
      .found (found),
      .idx   (winner)
   );

   assign win_data   = data[W*int'(winner) +: W];
   assign win_onehot = {{(NCH-1){1'b0}}, 1'b1} << winner;

   // out_data/out_chan are only written on a grant, so they hold through HOLD and after accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ack       <= '0;
         ptr       <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (enable && found) begin
                  state     <= ST_HOLD;
                  out_valid <= 1'b1;
                  out_data  <= win_data;
                  out_chan  <= winner;
                  ack       <= win_onehot;
                  if (MODE == MODE_RR)
                     ptr <= (winner == CW'(NCH - 1)) ? '0 : winner + 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_chan_mux.sv
// tb/tb_rr_chan_mux.sv - randomized and directed checks of rr_chan_mux in both arbitration modes
module tb_rr_chan_mux;

   localparam int NCH = 20;
   localparam int W   = 8;
   localparam int CW  = $clog2(NCH);

   logic             clk;
   logic             reset;
   logic             enable;
   logic [NCH-1:0]   req;
   logic [NCH*W-1:0] data;
   logic             out_ready;

   logic [NCH-1:0]   ack_d   [2];
   logic             valid_d [2];
   logic [W-1:0]     odata_d [2];
   logic [CW-1:0]    chan_d  [2];

   bit               m_busy [2];
   int               m_ptr  [2];
   int               m_chan [2];
   logic [W-1:0]     m_data [2];
   logic [NCH-1:0]   m_ack  [2];

   int n_vec;
   int n_err;
   int last_grant;
   int grants;

   rr_chan_mux #(.NCH(NCH), .W(W), .MODE(0)) u_dut_rr (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .data      (data),
      .ack       (ack_d[0]),
      .out_valid (valid_d[0]),
      .out_ready (out_ready),
      .out_data  (odata_d[0]),
      .out_chan  (chan_d[0])
   );

   rr_chan_mux #(.NCH(NCH), .W(W), .MODE(1)) u_dut_fixed (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .data      (data),
      .ack       (ack_d[1]),
      .out_valid (valid_d[1]),
      .out_ready (out_ready),
      .out_data  (odata_d[1]),
      .out_chan  (chan_d[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input int md, input int base, input logic [NCH-1:0] r);
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (md == 1) ? k : (base + k) % NCH;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int md = 0; md < 2; md++) begin
         m_busy[md] = 1'b0;
         m_ptr[md]  = 0;
         m_chan[md] = 0;
         m_data[md] = '0;
         m_ack[md]  = '0;
      end
   endtask

   // Advance the reference one clock using the inputs as they stand, then compare both DUTs.
   task automatic step();
      for (int md = 0; md < 2; md++) begin
         if (!reset) begin
            m_busy[md] = 1'b0;
            m_ptr[md]  = 0;
            m_chan[md] = 0;
            m_data[md] = '0;
            m_ack[md]  = '0;
         end else begin
            m_ack[md] = '0;
            if (!m_busy[md]) begin
               if (enable && req != '0) begin
                  int w;
                  w = pick(md, m_ptr[md], req);
                  m_busy[md]    = 1'b1;
                  m_chan[md]    = w;
                  m_data[md]    = data[w*W +: W];
                  m_ack[md][w]  = 1'b1;
                  if (md == 0) m_ptr[md] = (w + 1) % NCH;
               end
            end else if (out_ready) begin
               m_busy[md] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int md = 0; md < 2; md++) begin
         chk($sformatf("m%0d_valid", md), 64'(valid_d[md]), 64'(m_busy[md]));
         chk($sformatf("m%0d_chan", md),  64'(chan_d[md]),  64'(m_chan[md]));
         chk($sformatf("m%0d_data", md),  64'(odata_d[md]), 64'(m_data[md]));
         chk($sformatf("m%0d_ack", md),   64'(ack_d[md]),   64'(m_ack[md]));
      end
   endtask

   task automatic set_data(input int ch, input logic [W-1:0] v);
      data[ch*W +: W] = v;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      step();
      reset = 1'b1;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset      = 1'b0;
      enable     = 1'b1;
      out_ready  = 1'b0;
      req        = '1;
      data       = '0;
      for (int i = 0; i < NCH; i++) set_data(i, W'(i + 8'h10));
      model_reset();

      // Held in reset with every channel requesting
      repeat (5) step();
      chk("rst_valid", 64'(valid_d[0]), 64'd0);
      chk("rst_ack",   64'(ack_d[0]),   64'd0);
      chk("rst_chan",  64'(chan_d[0]),  64'd0);
      reset = 1'b1;
      step();
      chk("first_chan", 64'(chan_d[0]), 64'd0);
      chk("first_ack",  64'(ack_d[0]),  64'h00001);

      // Round-robin sweep with wrap
      out_ready  = 1'b1;
      last_grant = 0;
      grants     = 0;
      for (int s = 0; s < 42; s++) begin
         step();
         if (ack_d[0] != '0) begin
            grants++;
            chk("rr_order", 64'(chan_d[0]), 64'((last_grant + 1) % NCH));
            chk("rr_data",  64'(odata_d[0]), 64'(chan_d[0]) + 64'h10);
            last_grant = int'(chan_d[0]);
         end
      end
      chk("rr_grant_rate", 64'(grants), 64'd21);

      // Pointer at 5 after a grant to 4, then requests 3 and 17
      do_reset();
      req = 20'h00010;
      step();
      req = '0;
      step();
      req = 20'h20008;
      step();
      chk("ptr5_ack_a", 64'(ack_d[0]), 64'h20000);
      step();
      step();
      chk("ptr5_ack_b", 64'(ack_d[0]), 64'h00008);
      step();

      // Backpressure while the source data changes underneath
      req = 20'h00080;
      set_data(7, 8'hA5);
      step();
      req       = '0;
      out_ready = 1'b0;
      set_data(7, 8'h00);
      for (int s = 0; s < 6; s++) begin
         step();
         chk("bp_valid", 64'(valid_d[0]), 64'd1);
         chk("bp_data",  64'(odata_d[0]), 64'hA5);
         chk("bp_ack",   64'(ack_d[0]),   64'd0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release", 64'(valid_d[0]), 64'd0);

      // Fixed priority keeps picking 3, and enable=0 parks it after the current transfer
      req = 20'h20008;
      for (int s = 0; s < 8; s++) begin
         step();
         if (ack_d[1] != '0) chk("fix_chan", 64'(chan_d[1]), 64'd3);
      end
      if (!valid_d[1]) step();
      enable = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("dis_valid", 64'(valid_d[1]), 64'd0);
         chk("dis_ack",   64'(ack_d[1]),   64'd0);
      end
      enable = 1'b1;

      // Random traffic
      for (int s = 0; s < 400; s++) begin
         req       = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) == 1) set_data(int'($urandom_range(0, NCH - 1)), W'($urandom));
         step();
      end

      // Asynchronous reset in the middle of a held transfer
      enable    = 1'b1;
      out_ready = 1'b1;
      req       = '0;
      step();
      step();
      req       = 20'h01000;
      out_ready = 1'b0;
      step();
      chk("ar_chan", 64'(chan_d[0]), 64'd12);
      reset = 1'b0;
      #1;
      model_reset();
      chk("ar_valid_rr",  64'(valid_d[0]), 64'd0);
      chk("ar_valid_fix", 64'(valid_d[1]), 64'd0);
      step();
      req       = '1;
      out_ready = 1'b1;
      reset     = 1'b1;
      step();
      chk("ar_regrant", 64'(chan_d[0]), 64'd0);
      chk("ar_ack",     64'(ack_d[0]),  64'h00001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
